// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared shift op encodings and ALU widths
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 6;

    typedef enum logic [1:0] {
        SHOP_ROL = 2'd0,
        SHOP_SLL = 2'd1,
        SHOP_SRL = 2'd2,
        SHOP_SRA = 2'd3
    } shop_e;

endpackage

// File: rtl/shift.sv
// rtl/shift.sv - combinational left-only barrel shifter core
//
// Ports:
//   clk  - present for drop-in compatibility, not used
//   a    - operand
//   s    - shift amount
//   rot  - upper half of {a,a} << s (rotate-left result for s < 32)
//   lsh  - lower half of {a,a} << s (logical shift-left result)
module shift
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic [DATA_W-1:0] a,
    input  logic [AMT_W-1:0]  s,
    output logic [DATA_W-1:0] rot,
    output logic [DATA_W-1:0] lsh
);

    logic [2*DATA_W-1:0] wide;
    logic                unused_clk;

    assign unused_clk = clk;
    assign wide       = {a, a} << s;
    assign rot        = wide[2*DATA_W-1:DATA_W];
    assign lsh        = wide[DATA_W-1:0];

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin shared shifter with registered result buffer
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - per-port request handshake (bit i = port i)
//   req_op*/data*/amt*    - per-port op (ROL/SLL/SRL/SRA), operand, amount
//   rsp_valid/rsp_ready   - result buffer handshake
//   rsp_id, rsp_data      - issuing port and result
module shift_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_op0,
    input  logic [1:0]        req_op1,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [AMT_W-1:0]  req_amt0,
    input  logic [AMT_W-1:0]  req_amt1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data
);

    // Turns the core's left-shift outputs into the requested op result.
    // Right shifts are done as a left rotate by 32-n followed by masking off
    // the bits that wrapped around; SRA then refills them with the sign.
    function automatic logic [DATA_W-1:0] fix_result(
        input logic [1:0]        op,
        input logic [AMT_W-1:0]  amt,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] rot,
        input logic [DATA_W-1:0] lsh
    );
        logic [4:0]        n;
        logic              big;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] res;
        n    = amt[4:0];
        big  = amt[5];
        mask = {DATA_W{1'b1}} >> n;
        case (shop_e'(op))
            SHOP_ROL: res = rot;
            SHOP_SLL: res = big ? '0 : lsh;
            SHOP_SRL: res = big ? '0 : (rot & mask);
            SHOP_SRA: res = big ? {DATA_W{a[DATA_W-1]}}
                                : ((rot & mask) | (a[DATA_W-1] ? ~mask : '0));
            default:  res = rot;
        endcase
        return res;
    endfunction

    logic              last_q, last_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [1:0]        grant;
    logic              free;
    logic              accept;
    logic              sel;
    logic [1:0]        sel_op;
    logic [DATA_W-1:0] sel_data;
    logic [AMT_W-1:0]  sel_amt;
    logic [AMT_W-1:0]  core_s;
    logic [DATA_W-1:0] core_rot;
    logic [DATA_W-1:0] core_lsh;

    // A lone requester always wins; on contention the port not granted last wins.
    assign grant[0] = req_valid[0] && (!req_valid[1] || last_q);
    assign grant[1] = req_valid[1] && (!req_valid[0] || !last_q);

    assign free      = !rsp_valid_q || rsp_ready;
    assign req_ready = rst ? 2'b00 : (grant & {2{free}});
    assign accept    = |req_ready;
    assign sel       = grant[1];

    assign sel_op   = sel ? req_op1   : req_op0;
    assign sel_data = sel ? req_data1 : req_data0;
    assign sel_amt  = sel ? req_amt1  : req_amt0;

    // Right shifts rotate left by (32 - n) mod 32; s[5] is always kept low
    // so the core only ever rotates within one word.
    always_comb begin
        core_s = {1'b0, sel_amt[4:0]};
        if (sel_op == SHOP_SRL || sel_op == SHOP_SRA) begin
            core_s = {1'b0, 5'd0 - sel_amt[4:0]};
        end
    end

    shift u_shift (
        .clk (clk),
        .a   (sel_data),
        .s   (core_s),
        .rot (core_rot),
        .lsh (core_lsh)
    );

    always_comb begin
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (accept) begin
            last_d      = sel;
            rsp_valid_d = 1'b1;
            rsp_id_d    = sel;
            rsp_data_d  = fix_result(sel_op, sel_amt, sel_data, core_rot, core_lsh);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard testbench for shift_arbiter
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_op0 = 2'd0, req_op1 = 2'd0;
    logic [31:0] req_data0 = '0, req_data1 = '0;
    logic [5:0]  req_amt0 = '0, req_amt1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [31:0] rsp_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    shift_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_amt0  (req_amt0),
        .req_amt1  (req_amt1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [5:0] amt);
        logic [31:0] r;
        int          n;
        n = int'(amt[4:0]);
        r = a;
        case (op)
            2'd0: for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
            2'd1: r = amt[5] ? 32'h0 : (a << n);
            2'd2: r = amt[5] ? 32'h0 : (a >> n);
            default: r = amt[5] ? {32{a[31]}} : 32'($signed(a) >>> n);
        endcase
        return r;
    endfunction

    // One clock: at the falling edge retire/compare results and record
    // accepted requests, then advance past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        checks++;
        if (rsp_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL rsp_valid_track got %0b exp %0b", rsp_valid, sb.size() != 0);
        end
        checks++;
        if (req_ready === 2'b11) begin
            errors++;
            $display("FAIL one_hot_ready got %b exp at most one bit", req_ready);
        end
        if (rsp_valid === 1'b1 && rsp_ready && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (rsp_id !== e.id || rsp_data !== e.data) begin
                errors++;
                $display("FAIL scoreboard got id %0b data %h exp id %0b data %h",
                         rsp_id, rsp_data, e.id, e.data);
            end
        end
        if (req_ready[0] === 1'b1) sb.push_back('{1'b0, model(req_op0, req_data0, req_amt0)});
        if (req_ready[1] === 1'b1) sb.push_back('{1'b1, model(req_op1, req_data1, req_amt1)});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got v %0b id %0b d %h exp 0 0 0", rsp_valid, rsp_id, rsp_data);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got %b exp 00", req_ready);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_op_sweep();
        logic [31:0] exp_tab [4] = '{32'h0000_0F18, 32'h0000_0F10, 32'h0800_000F, 32'hF800_000F};
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_op0 = 2'(k);
            req_data0 = 32'h8000_00F1;
            req_amt0 = 6'd4;
            req_valid = 2'b01;
            cycle();
            req_valid = 2'b00;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== exp_tab[k]) begin
                errors++;
                $display("FAIL sweep_op%0d got v %0b id %0b d %h exp 1 0 %h",
                         k, rsp_valid, rsp_id, rsp_data, exp_tab[k]);
            end
            cycle();
            checks++;
            if (rsp_valid !== 1'b0 || rsp_data !== exp_tab[k]) begin
                errors++;
                $display("FAIL drain_keep_op%0d got v %0b d %h exp 0 %h", k, rsp_valid, rsp_data, exp_tab[k]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [1:0]  ops  [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        logic [5:0]  amts [10] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd31, 6'd32, 6'd32, 6'd32, 6'd32, 6'd63};
        logic [31:0] exps [10] = '{32'hC000_0001, 32'hC000_0001, 32'hC000_0001, 32'hC000_0001,
                                   32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF,
                                   32'hC000_0001, 32'hE000_0000};
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req_op1 = ops[k];
            req_data1 = 32'hC000_0001;
            req_amt1 = amts[k];
            req_valid = 2'b10;
            cycle();
            req_valid = 2'b00;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== exps[k]) begin
                errors++;
                $display("FAIL boundary_%0d op %0d amt %0d got v %0b id %0b d %h exp 1 1 %h",
                         k, ops[k], amts[k], rsp_valid, rsp_id, rsp_data, exps[k]);
            end
            cycle();
        end
    endtask

    task automatic test_contention();
        do_reset();
        rsp_ready = 1'b1;
        req_op0 = 2'($urandom_range(0, 3)); req_data0 = $urandom; req_amt0 = 6'($urandom_range(0, 63));
        req_op1 = 2'($urandom_range(0, 3)); req_data1 = $urandom; req_amt1 = 6'($urandom_range(0, 63));
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'(k % 2)) begin
                errors++;
                $display("FAIL contention_%0d got v %0b id %0b exp 1 %0d", k, rsp_valid, rsp_id, k % 2);
            end
            if (k % 2 == 0) begin
                req_op0 = 2'($urandom_range(0, 3)); req_data0 = $urandom; req_amt0 = 6'($urandom_range(0, 63));
            end else begin
                req_op1 = 2'($urandom_range(0, 3)); req_data1 = $urandom; req_amt1 = 6'($urandom_range(0, 63));
            end
        end
        req_valid = 2'b00;
        cycle();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        for (int k = 0; k < 8; k++) begin
            req_op0 = 2'($urandom_range(0, 3));
            req_data0 = $urandom;
            req_amt0 = 6'($urandom_range(0, 63));
            cycle();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back_%0d got v %0b id %0b exp 1 0", k, rsp_valid, rsp_id);
            end
        end
        req_valid = 2'b00;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        rsp_ready = 1'b0;
        req_op0 = 2'd1; req_data0 = $urandom; req_amt0 = 6'($urandom_range(0, 31));
        held = model(req_op0, req_data0, req_amt0);
        req_valid = 2'b01;
        cycle();
        req_op1 = 2'd3; req_data1 = $urandom | 32'h8000_0000; req_amt1 = 6'd7;
        req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_data !== held || rsp_id !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got rdy %b v %0b id %0b d %h exp 00 1 0 %h",
                         k, req_ready, rsp_valid, rsp_id, rsp_data, held);
            end
            cycle();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL release_ready got %b exp 10", req_ready);
        end
        cycle();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL release_result got v %0b id %0b exp 1 1", rsp_valid, rsp_id);
        end
        cycle();
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b0;
        req_op0 = 2'd0; req_data0 = 32'h1234_5678; req_amt0 = 6'd0;
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL midflight_load got v %0b d %h exp 1 12345678", rsp_valid, rsp_data);
        end
        rst = 1'b1;
        cycle();
        sb.delete();
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL midflight_reset got v %0b d %h exp 0 0", rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1;
        req_data1 = 32'hA5A5_0F0F; req_op1 = 2'd2; req_amt1 = 6'd3;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midflight_first_grant got %b exp 01", req_ready);
        end
        cycle();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL midflight_first_id got v %0b id %0b exp 1 0", rsp_valid, rsp_id);
        end
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_op_sweep();
        test_boundary();
        test_contention();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
